// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller for an ID-stage branch comparator.
// Decides when a branch waits for producers, how its operands forward, and whether it redirects.
module branch_hazard_ctrl (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        ID_is_branch,
  input  logic [2:0]  ID_funct3,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [4:0]  IDEX_rd,
  input  logic        IDEX_RegWrite,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  EXMEM_rd,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  MEMWB_rd,
  input  logic        MEMWB_RegWrite,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic        EX_flush,
  input  logic        clr_cnt,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        is_sign,
  output logic        stall,
  output logic        br_taken,
  output logic        flush_IFID,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic [1:0] n;
  logic       idex_match, exmem_match;
  logic       stall_int, resolve, taken_dec;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    idex_match  = (IDEX_rd  != 5'd0) && ((IDEX_rd  == ID_rs1) || (IDEX_rd  == ID_rs2));
    exmem_match = (EXMEM_rd != 5'd0) && ((EXMEM_rd == ID_rs1) || (EXMEM_rd == ID_rs2));
    if (IDEX_RegWrite && IDEX_MemRead && idex_match)
      n = 2'd2;
    else if (IDEX_RegWrite && idex_match)
      n = 2'd1;
    else if (EXMEM_RegWrite && EXMEM_MemRead && exmem_match)
      n = 2'd1;
    else
      n = 2'd0;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_int  = 1'b0;
    resolve    = 1'b0;
    case (state)
      IDLE: begin
        if (ID_is_branch) begin
          if (n == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall_int  = 1'b1;
            cnt_next   = n - 2'd1;
            state_next = (n == 2'd1) ? RESOLVE : WAIT;
          end
        end
      end
      WAIT: begin
        stall_int = 1'b1;
        if (cnt != 2'd0) cnt_next = cnt - 2'd1;
        // cnt should never be 0 here; treating it like 1 keeps the FSM from locking up
        if (cnt <= 2'd1) state_next = RESOLVE;
      end
      RESOLVE: begin
        resolve    = ID_is_branch;
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
    // An older redirect kills whatever is in ID, including a branch mid-stall
    if (EX_flush) begin
      stall_int  = 1'b0;
      resolve    = 1'b0;
      state_next = IDLE;
      cnt_next   = 2'd0;
    end
  end

  always_comb begin
    case (ID_funct3)
      3'b000:          taken_dec = BrEq;
      3'b001:          taken_dec = ~BrEq;
      3'b100, 3'b110:  taken_dec = BrLt;
      3'b101, 3'b111:  taken_dec = ~BrLt;
      default:         taken_dec = 1'b0;
    endcase
  end

  always_comb begin
    if (EXMEM_RegWrite && (EXMEM_rd != 5'd0) && (EXMEM_rd == ID_rs1))      fwd_a = 2'b10;
    else if (MEMWB_RegWrite && (MEMWB_rd != 5'd0) && (MEMWB_rd == ID_rs1)) fwd_a = 2'b01;
    else                                                                   fwd_a = 2'b00;
    if (EXMEM_RegWrite && (EXMEM_rd != 5'd0) && (EXMEM_rd == ID_rs2))      fwd_b = 2'b10;
    else if (MEMWB_RegWrite && (MEMWB_rd != 5'd0) && (MEMWB_rd == ID_rs2)) fwd_b = 2'b01;
    else                                                                   fwd_b = 2'b00;
  end

  // Outputs are gated by RSTn so they are quiet for the whole reset window
  assign is_sign    = ~(ID_funct3[2] & ID_funct3[1]);
  assign stall      = RSTn & stall_int;
  assign br_taken   = RSTn & resolve & taken_dec;
  assign flush_IFID = br_taken;
  assign forwardA   = (RSTn && resolve) ? fwd_a : 2'b00;
  assign forwardB   = (RSTn && resolve) ? fwd_b : 2'b00;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      branch_cnt <= 16'd0;
      taken_cnt  <= 16'd0;
      stall_cnt  <= 16'd0;
    end else if (clr_cnt) begin
      branch_cnt <= 16'd0;
      taken_cnt  <= 16'd0;
      stall_cnt  <= 16'd0;
    end else begin
      if (resolve)  branch_cnt <= branch_cnt + 16'd1;
      if (br_taken) taken_cnt  <= taken_cnt + 16'd1;
      if (stall)    stall_cnt  <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: a cycle-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        ID_is_branch, EX_flush, clr_cnt, BrEq, BrLt;
  logic [2:0]  ID_funct3;
  logic [4:0]  ID_rs1, ID_rs2, IDEX_rd, EXMEM_rd, MEMWB_rd;
  logic        IDEX_RegWrite, IDEX_MemRead, EXMEM_RegWrite, EXMEM_MemRead, MEMWB_RegWrite;
  logic [1:0]  forwardA, forwardB;
  logic        is_sign, stall, br_taken, flush_IFID;
  logic [15:0] branch_cnt, taken_cnt, stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a branch owes 'owed' more stall cycles before it resolves while 'pend' is set
  bit pend;
  int owed;
  int m_bcnt, m_tcnt, m_scnt;
  int e_n;
  bit e_stall, e_res, e_tk;

  always #5 CLK = ~CLK;

  branch_hazard_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .ID_is_branch(ID_is_branch), .ID_funct3(ID_funct3),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .IDEX_rd(IDEX_rd), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_MemRead(IDEX_MemRead), .EXMEM_rd(EXMEM_rd), .EXMEM_RegWrite(EXMEM_RegWrite),
    .EXMEM_MemRead(EXMEM_MemRead), .MEMWB_rd(MEMWB_rd), .MEMWB_RegWrite(MEMWB_RegWrite),
    .BrEq(BrEq), .BrLt(BrLt), .EX_flush(EX_flush), .clr_cnt(clr_cnt),
    .forwardA(forwardA), .forwardB(forwardB), .is_sign(is_sign), .stall(stall),
    .br_taken(br_taken), .flush_IFID(flush_IFID),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit uses(input logic [4:0] rd);
    return (rd != 5'd0) && (rd == ID_rs1 || rd == ID_rs2);
  endfunction

  function automatic int depth();
    if (IDEX_RegWrite && IDEX_MemRead && uses(IDEX_rd)) return 2;
    if (IDEX_RegWrite && uses(IDEX_rd)) return 1;
    if (EXMEM_RegWrite && EXMEM_MemRead && uses(EXMEM_rd)) return 1;
    return 0;
  endfunction

  function automatic int fwd(input logic [4:0] rs);
    if (EXMEM_RegWrite && EXMEM_rd != 5'd0 && EXMEM_rd == rs) return 2;
    if (MEMWB_RegWrite && MEMWB_rd != 5'd0 && MEMWB_rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit outcome();
    case (ID_funct3)
      3'd0: return BrEq;
      3'd1: return !BrEq;
      3'd4, 3'd6: return BrLt;
      3'd5, 3'd7: return !BrLt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_inputs();
    ID_is_branch = 0; ID_funct3 = 0; ID_rs1 = 0; ID_rs2 = 0;
    IDEX_rd = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
    EXMEM_rd = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
    MEMWB_rd = 0; MEMWB_RegWrite = 0;
    BrEq = 0; BrLt = 0; EX_flush = 0; clr_cnt = 0;
  endtask

  // Let inputs settle, derive the expected outputs and compare them all
  task automatic settle();
    #1;
    e_stall = 0; e_res = 0; e_n = depth();
    if (!RSTn) begin
      pend = 0; owed = 0; m_bcnt = 0; m_tcnt = 0; m_scnt = 0;
    end else if (!EX_flush) begin
      if (pend) begin
        if (owed > 0) e_stall = 1;
        else e_res = ID_is_branch;
      end else if (ID_is_branch) begin
        if (e_n == 0) e_res = 1;
        else e_stall = 1;
      end
    end
    e_tk = e_res && outcome();
    chk("stall", int'(stall), int'(e_stall));
    chk("br_taken", int'(br_taken), int'(e_tk));
    chk("flush_IFID", int'(flush_IFID), int'(e_tk));
    chk("forwardA", int'(forwardA), e_res ? fwd(ID_rs1) : 0);
    chk("forwardB", int'(forwardB), e_res ? fwd(ID_rs2) : 0);
    chk("is_sign", int'(is_sign), (ID_funct3 == 3'd6 || ID_funct3 == 3'd7) ? 0 : 1);
    chk("branch_cnt", int'(branch_cnt), m_bcnt);
    chk("taken_cnt", int'(taken_cnt), m_tcnt);
    chk("stall_cnt", int'(stall_cnt), m_scnt);
  endtask

  task automatic advance();
    @(posedge CLK);
    if (RSTn) begin
      if (EX_flush) begin
        pend = 0; owed = 0;
      end else if (pend) begin
        if (owed > 0) owed--;
        else pend = 0;
      end else if (ID_is_branch && e_n > 0) begin
        pend = 1; owed = e_n - 1;
      end
      if (clr_cnt) begin
        m_bcnt = 0; m_tcnt = 0; m_scnt = 0;
      end else begin
        m_bcnt = (m_bcnt + int'(e_res)) % 65536;
        m_tcnt = (m_tcnt + int'(e_tk)) % 65536;
        m_scnt = (m_scnt + int'(e_stall)) % 65536;
      end
    end
    @(negedge CLK);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  initial begin
    clear_inputs();
    pend = 0; owed = 0; m_bcnt = 0; m_tcnt = 0; m_scnt = 0;
    @(negedge CLK);
    ID_is_branch = 1; BrEq = 1;
    settle();
    chk("reset_stall", int'(stall), 0);
    chk("reset_taken", int'(br_taken), 0);
    advance();
    RSTn = 1;
    clear_inputs();
    tick();

    // Hazard-free BEQ x5,x5 resolves at once
    ID_is_branch = 1; ID_funct3 = 3'd0; ID_rs1 = 5; ID_rs2 = 5; BrEq = 1;
    settle();
    chk("beq_taken", int'(br_taken), 1);
    chk("beq_flush", int'(flush_IFID), 1);
    chk("beq_fwd", int'({forwardA, forwardB}), 0);
    advance();
    clear_inputs();
    settle();
    chk("beq_bcnt", int'(branch_cnt), 1);
    advance();

    // BLT x3,x4 with an ALU op writing x3 one stage ahead
    ID_is_branch = 1; ID_funct3 = 3'd4; ID_rs1 = 3; ID_rs2 = 4;
    IDEX_rd = 3; IDEX_RegWrite = 1;
    settle();
    chk("blt_stall", int'(stall), 1);
    advance();
    IDEX_rd = 0; IDEX_RegWrite = 0; EXMEM_rd = 3; EXMEM_RegWrite = 1; BrLt = 1;
    settle();
    chk("blt_nostall", int'(stall), 0);
    chk("blt_fwdA", int'(forwardA), 2);
    chk("blt_taken", int'(br_taken), 1);
    advance();
    clear_inputs();
    settle();
    chk("blt_scnt", int'(stall_cnt), 1);
    advance();

    // BGEU x7,x8 behind a load to x8: two stall cycles
    ID_is_branch = 1; ID_funct3 = 3'd7; ID_rs1 = 7; ID_rs2 = 8;
    IDEX_rd = 8; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    settle();
    chk("bgeu_stall1", int'(stall), 1);
    advance();
    IDEX_rd = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
    EXMEM_rd = 8; EXMEM_RegWrite = 1; EXMEM_MemRead = 1;
    settle();
    chk("bgeu_stall2", int'(stall), 1);
    advance();
    EXMEM_rd = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
    MEMWB_rd = 8; MEMWB_RegWrite = 1; BrLt = 0;
    settle();
    chk("bgeu_nostall", int'(stall), 0);
    chk("bgeu_fwdB", int'(forwardB), 1);
    chk("bgeu_sign", int'(is_sign), 0);
    chk("bgeu_taken", int'(br_taken), 1);
    advance();
    clear_inputs();

    // Load hazard, then EX_flush while waiting
    ID_is_branch = 1; ID_funct3 = 3'd0; ID_rs1 = 9; ID_rs2 = 1; BrEq = 1;
    IDEX_rd = 9; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    tick();
    IDEX_rd = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0; EX_flush = 1;
    settle();
    chk("flush_stall", int'(stall), 0);
    chk("flush_taken", int'(br_taken), 0);
    advance();
    EX_flush = 0; ID_rs1 = 5; ID_rs2 = 5;
    settle();
    chk("flush_bcnt", int'(branch_cnt), 3);
    chk("flush_idle", int'(br_taken), 1);
    advance();
    clear_inputs();

    // Reset asserted in the middle of a wait
    ID_is_branch = 1; ID_funct3 = 3'd0; ID_rs1 = 10; ID_rs2 = 0;
    IDEX_rd = 10; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    tick();
    RSTn = 0;
    settle();
    chk("rst_stall", int'(stall), 0);
    chk("rst_bcnt", int'(branch_cnt), 0);
    chk("rst_scnt", int'(stall_cnt), 0);
    advance();
    RSTn = 1;
    clear_inputs();
    ID_is_branch = 1; ID_funct3 = 3'd1; ID_rs1 = 5; ID_rs2 = 6; BrEq = 1;
    settle();
    chk("bne_taken", int'(br_taken), 0);
    chk("bne_stall", int'(stall), 0);
    advance();
    clear_inputs();
    settle();
    chk("bne_bcnt", int'(branch_cnt), 1);
    advance();

    // Counter wrap and clear priority
    clr_cnt = 1;
    tick();
    clr_cnt = 0;
    ID_is_branch = 1; ID_funct3 = 3'd0; ID_rs1 = 5; ID_rs2 = 5; BrEq = 1;
    for (int i = 0; i < 65535; i++) tick();
    settle();
    chk("wrap_pre", int'(taken_cnt), 65535);
    advance();
    clr_cnt = 1;
    settle();
    chk("wrap_taken", int'(taken_cnt), 0);
    chk("wrap_bcnt", int'(branch_cnt), 0);
    advance();
    clr_cnt = 0;
    settle();
    chk("clr_bcnt", int'(branch_cnt), 0);
    chk("clr_tcnt", int'(taken_cnt), 0);
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ID_is_branch   = ($urandom_range(0, 1) == 1);
      ID_funct3      = 3'($urandom_range(0, 7));
      ID_rs1         = 5'($urandom_range(0, 6));
      ID_rs2         = 5'($urandom_range(0, 6));
      IDEX_rd        = 5'($urandom_range(0, 6));
      IDEX_RegWrite  = ($urandom_range(0, 1) == 1);
      IDEX_MemRead   = ($urandom_range(0, 2) == 0);
      EXMEM_rd       = 5'($urandom_range(0, 6));
      EXMEM_RegWrite = ($urandom_range(0, 1) == 1);
      EXMEM_MemRead  = ($urandom_range(0, 2) == 0);
      MEMWB_rd       = 5'($urandom_range(0, 6));
      MEMWB_RegWrite = ($urandom_range(0, 1) == 1);
      BrEq           = ($urandom_range(0, 1) == 1);
      BrLt           = ($urandom_range(0, 1) == 1);
      EX_flush       = ($urandom_range(0, 9) == 0);
      clr_cnt        = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
